// File: rtl/mult_div_unit_if.sv
// Operand/command and result bundle for the multiply/divide unit.
// Pure wiring, no latency of its own.
// No backpressure: the requester watches busy before issuing start.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers, with MTHI/MTLO writes.
// Latency: start sampled at edge E, HI/LO written at E+32, done high for the cycle after.
// Backpressure: busy stalls the pipeline; start and moves are dropped while busy.
module mult_div_unit (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;     // multiplicand for multiply, divisor for divide
  logic [63:0] acc_q, acc_d;       // {partial product | remainder, multiplier | quotient}
  logic        neg_q, neg_d;       // product/quotient must be negated
  logic        neg_rem_q, neg_rem_d;
  logic        bzero_q, bzero_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        is_signed;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic        qbit;
  logic [63:0] acc_nxt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes for the incoming request; unsigned ops pass through untouched.
  always_comb begin
    is_signed = ~bus.op[0];
    a_abs     = (is_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    b_abs     = (is_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
  end

  // One iteration of shift-add multiply or restoring divide, plus the sign fix-up of its outcome.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    qbit      = ~div_diff[32];
    if (op_q[1]) begin
      acc_nxt = {(qbit ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], qbit};
    end else begin
      acc_nxt = {mul_sum, acc_q[31:1]};
    end
    prod_fix = neg_q ? (64'd0 - acc_nxt) : acc_nxt;
    quo_fix  = neg_q ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
  end

  // Next-state logic: accept a request or a move in IDLE, iterate in RUN, commit on the 32nd step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          cnt_d     = 5'd0;
          op_d      = bus.op;
          dbz_d     = 1'b0;
          neg_d     = is_signed & (bus.a[31] ^ bus.b[31]);
          neg_rem_d = is_signed & bus.a[31];
          bzero_d   = (bus.b == 32'd0);
          if (bus.op[1]) begin
            acc_d  = {32'd0, a_abs};
            opnd_d = b_abs;
          end else begin
            acc_d  = {32'd0, b_abs};
            opnd_d = a_abs;
          end
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      RUN: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (op_q[1]) begin
            // A zero divisor leaves the remainder equal to |a|, so the fix-up already yields a.
            hi_d  = rem_fix;
            lo_d  = bzero_q ? 32'hFFFF_FFFF : quo_fix;
            dbz_d = bzero_q;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit integer multiply/divide unit for the execute stage of the MIPS32 core, operating beside the ALU on the same rs/rt operands. It implements MULT, MULTU, DIV and DIVU over 32 cycles each, holds the architectural HI/LO registers, and supports MTHI/MTLO writes. The hazard logic stalls the pipeline on `busy`. The writeback mux selects `hi`/`lo` for MFHI/MFLO alongside the ALU `res`.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request an operation; sampled only when `busy`=0.
- `op` in 2: 2'd0 MULT, 2'd1 MULTU, 2'd2 DIV, 2'd3 DIVU; sampled with `start`.
- `a` in 32: rs operand (multiplicand / dividend); sampled with `start`.
- `b` in 32: rt operand (multiplier / divisor); sampled with `start`.
- `mthi` in 1: write `wdata` into HI.
- `mtlo` in 1: write `wdata` into LO.
- `wdata` in 32: data for MTHI/MTLO.
- `busy` out 1: an operation is in progress; HI/LO are stale.
- `done` out 1: one-cycle pulse; HI/LO now hold the new result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `div_by_zero` out 1: sticky flag; set by a DIV/DIVU with `b`=0; cleared by the next accepted `start`.

## Operation
- States: IDLE and RUN.
- IDLE → RUN when `start`=1. On that edge the unit latches `op`, |a|, |b| and the result signs, and clears the 5-bit counter.
  - For signed ops, |x| is the two's-complement magnitude, so 0x80000000 gives 2^31.
  - For unsigned ops, operands are taken as-is.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle. It uses a 33-bit partial remainder.
- RUN → IDLE on the edge where the counter reaches 31 (the 32nd RUN edge). On that edge HI/LO are written and `done`=1 for the following cycle.
- Sign fix-up:
  - MULT: the 64-bit product is negated if the operand signs differ. HI = upper 32 bits, LO = lower 32 bits.
  - DIV: the quotient is negated if the signs differ. The remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- Divide by zero (`b`=0, DIV or DIVU): the unit still runs the full 32 cycles. Results are HI = `a` and LO = 32'hFFFFFFFF, and `div_by_zero` is set with `done`.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, no flag.
- MTHI/MTLO:
  - Honoured only in IDLE with `start`=0.
  - The register updates on the next edge.
  - `mthi` and `mtlo` may be asserted together; both registers are written.
- Ignored inputs:
  - `start` while `busy`=1 is ignored (no queuing).
  - `mthi`/`mtlo` while `busy`=1 are ignored.
  - `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the moves are dropped.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0, state IDLE, counter 0.
- Reset during RUN aborts the operation. HI/LO return to 0 and no `done` is produced.
- Latency, with `start` sampled at edge E:
  - `busy`=1 in the cycles following edges E through E+31.
  - HI/LO are updated at edge E+32.
  - After edge E+32: `busy`=0 and `done`=1 for exactly one cycle.
- Back-to-back: a new `start` is accepted in the same cycle `done`=1, since `busy` is already 0 then. The next result lands 32 edges later.
- `busy` is a registered output. `hi`/`lo` are registered and change only on the result edge, an MTHI/MTLO edge, or reset. They are never combinational from the inputs.
- `a`, `b` and `op` need not be held after the start edge.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 → after 32 busy cycles, `done` pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 → LO=14, HI=2.
- DIVU a=0x12345678, b=0 → HI=0x12345678, LO=0xFFFFFFFF, `div_by_zero`=1. Next accepted `start` clears the flag.
- `start` reasserted with different operands mid-RUN, plus `mthi` wdata=0xDEAD mid-RUN → both ignored; the original result is intact. `mtlo` wdata=0xBEEF in IDLE → LO=0xBEEF the next cycle.
- MULTU 5×6 with `rst` pulsed at RUN cycle 10 → `busy`=0, `done` never pulses, HI=LO=0. A fresh MULTU 5×6 then → LO=30 after 32 cycles.
